// File: rtl/bebida_ctrl.sv
// Drink vending controller: coin credit, selection lock,
// timed valve dispense and unit-by-unit change return.
module bebida_ctrl #(
  parameter int DISP_CYCLES = 8,
  parameter int PRICE0      = 2,
  parameter int PRICE1      = 3,
  parameter int PRICE2      = 3,
  parameter int PRICE3      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] sel,
  input  logic       sel_valid,
  input  logic       coin,
  input  logic       cancel,
  output logic [3:0] credit,
  output logic [3:0] valve,
  output logic       change_pulse,
  output logic       busy,
  output logic [4:0] disp_code
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    PAY      = 3'b001,
    DISPENSE = 3'b010,
    REFUND   = 3'b011
  } state_t;

  localparam logic [3:0] P0 = 4'(PRICE0);
  localparam logic [3:0] P1 = 4'(PRICE1);
  localparam logic [3:0] P2 = 4'(PRICE2);
  localparam logic [3:0] P3 = 4'(PRICE3);
  localparam logic [7:0] DCNT = 8'(DISP_CYCLES);

  state_t     state;
  logic [1:0] sel_q;
  logic [7:0] cnt;
  logic [1:0] sync;
  logic       run;
  logic [3:0] price;
  logic [3:0] cred_inc;
  logic [3:0] cred_buy;
  logic       pay_ok;

  // Release synchroniser: FSM stays frozen until two edges after release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  assign run = sync[1];

  // Price of the locked selection
  always_comb begin
    price = P0;
    case (sel_q)
      2'd0:    price = P0;
      2'd1:    price = P1;
      2'd2:    price = P2;
      2'd3:    price = P3;
      default: price = P0;
    endcase
  end

  // Credit arithmetic: saturating coin add and purchase debit
  always_comb begin
    cred_inc = credit;
    if (coin && (credit != 4'hF)) begin
      cred_inc = credit + 4'd1;
    end
    pay_ok   = (credit >= price);
    cred_buy = credit - price + {3'b000, coin};
  end

  // Main FSM with credit, selection latch, dispense timer and valves
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      credit <= 4'd0;
      sel_q  <= 2'd0;
      cnt    <= 8'd0;
      valve  <= 4'd0;
    end else if (run) begin
      case (state)
        IDLE: begin
          credit <= cred_inc;
          if (cancel && (credit != 4'd0)) begin
            state <= REFUND;
          end else if (sel_valid) begin
            sel_q <= sel;
            state <= PAY;
          end
        end
        PAY: begin
          if (cancel) begin
            credit <= cred_inc;
            state  <= REFUND;
          end else if (pay_ok) begin
            credit <= cred_buy;
            cnt    <= DCNT;
            valve  <= 4'b0001 << sel_q;
            state  <= DISPENSE;
          end else begin
            credit <= cred_inc;
          end
        end
        DISPENSE: begin
          if (cnt <= 8'd1) begin
            cnt   <= 8'd0;
            valve <= 4'd0;
            state <= (credit != 4'd0) ? REFUND : IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        REFUND: begin
          if (credit != 4'd0) begin
            credit <= credit - 4'd1;
          end
          if (credit <= 4'd1) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
          valve <= 4'd0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only
  assign busy         = (state == DISPENSE) || (state == REFUND);
  assign change_pulse = (state == REFUND) && (credit != 4'd0);
  assign disp_code    = {state, sel_q};

endmodule

// File: tb/tb_bebida_ctrl.sv
// Directed self-checking bench for bebida_ctrl.
// Each task drives one scenario and checks its results inline.
module tb_bebida_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       sel_valid = 1'b0;
  logic       coin = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] credit;
  logic [3:0] valve;
  logic       change_pulse;
  logic       busy;
  logic [4:0] disp_code;

  int errors = 0;
  int checks = 0;

  bebida_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sel          (sel),
    .sel_valid    (sel_valid),
    .coin         (coin),
    .cancel       (cancel),
    .credit       (credit),
    .valve        (valve),
    .change_pulse (change_pulse),
    .busy         (busy),
    .disp_code    (disp_code)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic coins(input int n);
    coin = 1'b1;
    repeat (n) cyc();
    coin = 1'b0;
  endtask

  task automatic strobe(input logic [1:0] s);
    sel = s;
    sel_valid = 1'b1;
    cyc();
    sel_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if (credit !== 4'd0) begin
      errors++;
      $display("FAIL reset_credit got=%0d exp=0", credit);
    end
    checks++;
    if (valve !== 4'd0) begin
      errors++;
      $display("FAIL reset_valve got=%b exp=0000", valve);
    end
    checks++;
    if (busy !== 1'b0 || change_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_chg got=%b%b exp=00", busy, change_pulse);
    end
    checks++;
    if (disp_code !== 5'b00000) begin
      errors++;
      $display("FAIL reset_disp got=%b exp=00000", disp_code);
    end
    cyc();
    #2 reset_n = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic test_purchase();
    int vc;
    int pc;
    bit done;
    vc = 0;
    pc = 0;
    done = 0;
    strobe(2'd2);
    checks++;
    if (disp_code !== 5'b00110) begin
      errors++;
      $display("FAIL buy_pay got=%b exp=00110", disp_code);
    end
    coins(3);
    checks++;
    if (credit !== 4'd3 || disp_code !== 5'b00110) begin
      errors++;
      $display("FAIL buy_credit got=%0d/%b exp=3/00110", credit, disp_code);
    end
    cyc();
    checks++;
    if (disp_code !== 5'b01010 || valve !== 4'b0100 || credit !== 4'd0) begin
      errors++;
      $display("FAIL buy_disp got=%b/%b/%0d exp=01010/0100/0", disp_code, valve, credit);
    end
    for (int i = 0; i < 30; i++) begin
      if (valve == 4'b0100) vc++;
      if (change_pulse) pc++;
      if (disp_code[4:2] == 3'b000) begin
        done = 1;
        break;
      end
      cyc();
    end
    checks++;
    if (!done || vc != 8 || pc != 0 || credit !== 4'd0) begin
      errors++;
      $display("FAIL buy_end done=%0d valve=%0d pulses=%0d credit=%0d exp=1/8/0/0", done, vc, pc, credit);
    end
  endtask

  task automatic test_overpay();
    int vc;
    int pc;
    bit done;
    vc = 0;
    pc = 0;
    done = 0;
    coins(6);
    checks++;
    if (credit !== 4'd6) begin
      errors++;
      $display("FAIL over_load got=%0d exp=6", credit);
    end
    strobe(2'd0);
    cyc();
    checks++;
    if (credit !== 4'd4 || valve !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL over_disp got=%0d/%b/%b exp=4/0001/1", credit, valve, busy);
    end
    for (int i = 0; i < 40; i++) begin
      if (valve == 4'b0001) vc++;
      if (change_pulse) pc++;
      if (change_pulse && valve != 4'd0) pc += 100;
      if (disp_code[4:2] == 3'b000) begin
        done = 1;
        break;
      end
      cyc();
    end
    checks++;
    if (!done || vc != 8 || pc != 4 || credit !== 4'd0) begin
      errors++;
      $display("FAIL over_end done=%0d valve=%0d pulses=%0d credit=%0d exp=1/8/4/0", done, vc, pc, credit);
    end
  endtask

  task automatic test_cancel();
    int pc;
    int vc;
    bit done;
    pc = 0;
    vc = 0;
    done = 0;
    strobe(2'd3);
    coins(2);
    cancel = 1'b1;
    coin = 1'b1;
    cyc();
    cancel = 1'b0;
    coin = 1'b0;
    checks++;
    if (disp_code !== 5'b01111 || credit !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cancel_refund got=%b/%0d/%b exp=01111/3/1", disp_code, credit, busy);
    end
    for (int i = 0; i < 20; i++) begin
      if (change_pulse) pc++;
      if (valve != 4'd0) vc++;
      if (disp_code[4:2] == 3'b000) begin
        done = 1;
        break;
      end
      cyc();
    end
    checks++;
    if (!done || pc != 3 || vc != 0 || credit !== 4'd0) begin
      errors++;
      $display("FAIL cancel_end done=%0d pulses=%0d valve=%0d credit=%0d exp=1/3/0/0", done, pc, vc, credit);
    end
  endtask

  task automatic test_saturation_lock();
    int pc;
    bit done;
    pc = 0;
    done = 0;
    coins(17);
    checks++;
    if (credit !== 4'd15) begin
      errors++;
      $display("FAIL sat_credit got=%0d exp=15", credit);
    end
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (change_pulse) pc++;
      if (disp_code[4:2] == 3'b000) begin
        done = 1;
        break;
      end
      cyc();
    end
    checks++;
    if (!done || pc != 15) begin
      errors++;
      $display("FAIL sat_refund done=%0d pulses=%0d exp=1/15", done, pc);
    end
    strobe(2'd3);
    strobe(2'd1);
    checks++;
    if (disp_code !== 5'b00111) begin
      errors++;
      $display("FAIL lock_sel got=%b exp=00111", disp_code);
    end
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    cyc();
    checks++;
    if (disp_code[4:2] !== 3'b000 || credit !== 4'd0) begin
      errors++;
      $display("FAIL lock_exit got=%b/%0d exp=000/0", disp_code[4:2], credit);
    end
  endtask

  task automatic test_reset_mid_dispense();
    coins(5);
    strobe(2'd1);
    cyc();
    checks++;
    if (valve !== 4'b0010 || credit !== 4'd2) begin
      errors++;
      $display("FAIL mid_disp got=%b/%0d exp=0010/2", valve, credit);
    end
    repeat (3) cyc();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (valve !== 4'd0 || credit !== 4'd0 || disp_code !== 5'd0 || change_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got=%b/%0d/%b/%b exp=0000/0/00000/0", valve, credit, disp_code, change_pulse);
    end
    cyc();
    #2 reset_n = 1'b1;
    repeat (3) cyc();
    checks++;
    if (credit !== 4'd0 || disp_code !== 5'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got=%0d/%b/%b exp=0/00000/0", credit, disp_code, busy);
    end
  endtask

  task automatic test_idle_cancel();
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    checks++;
    if (disp_code[4:2] !== 3'b000 || change_pulse !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_cancel got=%b/%b/%b exp=000/0/0", disp_code[4:2], change_pulse, busy);
    end
    cyc();
    checks++;
    if (change_pulse !== 1'b0 || credit !== 4'd0) begin
      errors++;
      $display("FAIL idle_cancel2 got=%b/%0d exp=0/0", change_pulse, credit);
    end
  endtask

  task automatic test_release_sync();
    reset_n = 1'b0;
    #1;
    coin = 1'b1;
    #3 reset_n = 1'b1;
    cyc();
    checks++;
    if (credit !== 4'd0) begin
      errors++;
      $display("FAIL sync_hold got=%0d exp=0", credit);
    end
    repeat (3) cyc();
    coin = 1'b0;
    checks++;
    if (credit == 4'd0 || credit > 4'd2) begin
      errors++;
      $display("FAIL sync_run got=%0d exp=1..2", credit);
    end
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    repeat (3) cyc();
  endtask

  initial begin
    test_reset();
    test_purchase();
    test_overpay();
    test_cancel();
    test_saturation_lock();
    test_reset_mid_dispense();
    test_idle_cancel();
    test_release_sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
